// File: rtl/hour12_display_ctrl_if.sv
// hour12_display_ctrl_if: counter-side inputs and display-side outputs of the 12-hour display block.
interface hour12_display_ctrl_if;
    logic [3:0] cnt;
    logic       cnt_ld;
    logic       err_clr;
    logic       hr_tens;
    logic [3:0] hr_units;
    logic       pm;
    logic       wrap;
    logic       err;
    logic [6:0] seg;
    logic [1:0] an;
    modport master (output cnt, cnt_ld, err_clr, input hr_tens, hr_units, pm, wrap, err, seg, an);
    modport slave  (input cnt, cnt_ld, err_clr, output hr_tens, hr_units, pm, wrap, err, seg, an);
endinterface

// File: rtl/hour12_display_ctrl.sv
// hour12_display_ctrl: maps a mod-12 count to 1..12 BCD, tracks AM/PM and errors, scans a 2-digit display.
// Optional HOUR12_LEAD_BLANK_EN blanks a leading zero on the tens digit.
module hour12_display_ctrl #(
    parameter int unsigned SCAN_DIV = 4
) (
    input logic                   clk,
    input logic                   reset,
    hour12_display_ctrl_if.slave  bus
);
    localparam logic [0:0] UNITS = 1'b0;
    localparam logic [0:0] TENS  = 1'b1;
    localparam logic [7:0] TC    = 8'(SCAN_DIV - 1);

    logic [3:0] cnt_q;
    logic       ld_q;
    logic       hr_tens_q, hr_tens_d;
    logic [3:0] hr_units_q, hr_units_d;
    logic       pm_q, wrap_q, wrap_d, err_q, err_d;
    logic [6:0] seg_q, seg_d, units_seg, tens_seg;
    logic [1:0] an_q, an_d;
    logic [0:0] state_q, state_d;
    logic [7:0] presc_q, presc_d;
    logic       illegal;

    function automatic logic [6:0] enc7(input logic [3:0] d);
        case (d)
            4'd0: enc7 = 7'h3F;
            4'd1: enc7 = 7'h06;
            4'd2: enc7 = 7'h5B;
            4'd3: enc7 = 7'h4F;
            4'd4: enc7 = 7'h66;
            4'd5: enc7 = 7'h6D;
            4'd6: enc7 = 7'h7D;
            4'd7: enc7 = 7'h07;
            4'd8: enc7 = 7'h7F;
            4'd9: enc7 = 7'h6F;
            default: enc7 = 7'h40;
        endcase
    endfunction

    always_comb begin
        illegal    = bus.cnt >= 4'd12;
        hr_tens_d  = illegal ? 1'b0 : (bus.cnt == 4'd0 || bus.cnt >= 4'd10);
        hr_units_d = illegal ? 4'hF : bus.cnt == 4'd0 ? 4'd2 : bus.cnt >= 4'd10 ? bus.cnt - 4'd10 : bus.cnt;
        // a load/reset of the upstream counter on the previous cycle masks the wrap
        wrap_d     = cnt_q == 4'd11 && bus.cnt == 4'd0 && !ld_q;
        err_d      = illegal | (err_q & ~bus.err_clr);
        presc_d    = presc_q == TC ? 8'd0 : presc_q + 8'd1;
        state_d    = presc_q == TC ? ~state_q : state_q;
        units_seg  = enc7(hr_units_q);
`ifdef HOUR12_LEAD_BLANK_EN
        tens_seg   = hr_units_q == 4'hF ? 7'h40 : !hr_tens_q ? 7'h00 : enc7({3'b000, hr_tens_q});
`else
        tens_seg   = hr_units_q == 4'hF ? 7'h40 : enc7({3'b000, hr_tens_q});
`endif
        seg_d      = state_q == UNITS ? units_seg : tens_seg;
        an_d       = state_q == UNITS ? 2'b10 : 2'b01;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= 4'd0;
            ld_q       <= 1'b1;
            hr_tens_q  <= 1'b1;
            hr_units_q <= 4'd2;
            pm_q       <= 1'b0;
            wrap_q     <= 1'b0;
            err_q      <= 1'b0;
            seg_q      <= 7'h00;
            an_q       <= 2'b11;
            state_q    <= UNITS;
            presc_q    <= 8'd0;
        end else begin
            cnt_q      <= bus.cnt;
            ld_q       <= bus.cnt_ld;
            hr_tens_q  <= hr_tens_d;
            hr_units_q <= hr_units_d;
            pm_q       <= pm_q ^ wrap_d;
            wrap_q     <= wrap_d;
            err_q      <= err_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
            state_q    <= state_d;
            presc_q    <= presc_d;
        end
    end

    assign bus.hr_tens  = hr_tens_q;
    assign bus.hr_units = hr_units_q;
    assign bus.pm       = pm_q;
    assign bus.wrap     = wrap_q;
    assign bus.err      = err_q;
    assign bus.seg      = seg_q;
    assign bus.an       = an_q;
endmodule

// File: doc/hour12_display_ctrl.md
HOUR12_DISPLAY_CTRL -- requirements
Module: hour12_display_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 4, clock cycles per displayed digit; legal range 2..255.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 cnt  input  4  hour count from upstream mod-12 counter output (0..11 legal).
REQ-005 cnt_ld  input  1  high on any cycle where upstream counter load or reset is asserted.
REQ-006 err_clr  input  1  clears sticky error flag.
REQ-007 hr_tens  output  1  registered BCD tens digit of hour (1..12 format).
REQ-008 hr_units  output  4  registered BCD units digit of hour.
REQ-009 pm  output  1  AM/PM flag; 0 = AM, 1 = PM.
REQ-010 wrap  output  1  one-cycle pulse on a natural 11->0 wrap.
REQ-011 err  output  1  sticky flag; an illegal count (12..15) was sampled.
REQ-012 seg  output  7  segment drive {g,f,e,d,c,b,a}, active-high.
REQ-013 an  output  2  digit enable, active-low; an[0] = units, an[1] = tens.

Function
REQ-014 Block SHALL register cnt and cnt_ld every cycle into cnt_q and ld_q.
REQ-015 Hour mapping, latency 1 cycle from cnt: 0->12, 1..9->0/1..9, 10->10, 11->11.
REQ-016 Illegal cnt (12..15) SHALL set hr_tens=0 and hr_units=4'hF; the digit is displayed as dash (seg=7'h40 on both digits).
REQ-017 Wrap is detected when cnt_q==11, cnt==0 and ld_q==0. On detection, pm SHALL toggle and wrap SHALL pulse high on the next cycle.
REQ-018 Transitions 0 from 12..15, and any transition following a cycle with cnt_ld=1, SHALL NOT be wraps.
REQ-019 err SHALL set on the cycle after cnt>=12 is sampled. It clears only on err_clr or reset; if set and clear are simultaneous, set wins.
REQ-020 Scan FSM has states UNITS and TENS. A prescaler counts 0..SCAN_DIV-1; at terminal count the state alternates and the prescaler returns to 0.
REQ-021 In UNITS: an=2'b10, seg = encoding of hr_units. In TENS: an=2'b01, seg = encoding of hr_tens. seg and an are registered (1-cycle latency from state).
REQ-022 Encoding: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (hex).
REQ-023 Consecutive identical cnt values SHALL produce no pulse and no pm change.

Reset
REQ-024 Reset SHALL take priority over all other inputs on the same edge.
REQ-025 Reset values: cnt_q=0, ld_q=1, hr_tens=1, hr_units=2, pm=0, wrap=0, err=0, seg=7'h00, an=2'b11, scan state UNITS, prescaler 0.
REQ-026 After reset deasserts, the first digit drive is UNITS (an=2'b10), one cycle later.
REQ-027 Reset mid-scan SHALL abort the current digit with no partial carry-over of prescaler count.

Configuration
REQ-028 Macro HOUR12_LEAD_BLANK_EN, when defined: in TENS state with hr_tens==0, seg SHALL be 7'h00 (blank).
REQ-029 When HOUR12_LEAD_BLANK_EN is undefined, a tens digit of 0 SHALL display 7'h3F. All other behaviour is identical.

Verification
REQ-030 Reset, then hold cnt=0 -> hr_tens=1, hr_units=2, pm=0, err=0; an alternates 10/01 every 4 cycles (SCAN_DIV=4).
REQ-031 Drive cnt 10, 11, 0 on consecutive cycles with cnt_ld=0 -> wrap pulses exactly once, pm 0->1; a second such sequence -> pm 1->0.
REQ-032 Drive cnt=11, then cnt=0 with cnt_ld=1 on the prior cycle -> no wrap pulse, pm unchanged.
REQ-033 Drive cnt=13 -> err=1, seg=7'h40 on both digits; then cnt=13 with err_clr=1 -> err stays 1; cnt=5 with err_clr=1 -> err=0.
REQ-034 Drive cnt=7 with macro defined -> TENS seg=7'h00, UNITS seg=7'h07; with macro undefined -> TENS seg=7'h3F.
REQ-035 Assert reset on the same cycle as a wrap condition -> wrap=0, pm=0, an=2'b11 the following cycle.
